// File: rtl/memacc_pkg.sv
// Shared types and constants for the memory access controller.
// State encoding and address alignment helpers.
package memacc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } memacc_state_t;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic is_aligned(input logic [1:0] addr_lo);
    return (addr_lo & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/memacc_timer.sv
// Wait-cycle counter for the memory access controller.
// Loadable, clearable up-counter with a terminal-count flag.
module memacc_timer #(
  parameter int DATAWIDTH_TIMER = 4,
  parameter int TERMINAL        = 14
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       load,
  input  logic [DATAWIDTH_TIMER-1:0] load_value,
  input  logic                       enable,
  output logic                       terminal
);

  localparam logic [DATAWIDTH_TIMER-1:0] TC =
    DATAWIDTH_TIMER'(TERMINAL);

  logic [DATAWIDTH_TIMER-1:0] count;

  // Count wait cycles; clear has priority over load and increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == TC);

endmodule

// File: rtl/memory_access_controller.sv
// Sequences main-memory reads/writes for the microcoded control unit.
// Latches the access, waits for ready with a timeout, returns ACK.
module memory_access_controller
  import memacc_pkg::*;
#(
  parameter int DATAWIDTH_ADDRESS = 32,
  parameter int DATAWIDTH_DATA    = 32,
  parameter int TIMEOUT_CYCLES    = 15,
  parameter int DATAWIDTH_TIMER   = 4
) (
  input  logic                         MEMACC_CLOCK_50,
  input  logic                         MEMACC_ResetInLow_In,
  input  logic                         MEMACC_RD_In,
  input  logic                         MEMACC_WRMain_In,
  input  logic [DATAWIDTH_ADDRESS-1:0] MEMACC_Address_InBus,
  input  logic [DATAWIDTH_DATA-1:0]    MEMACC_WriteData_InBus,
  input  logic                         MEMACC_ClearError_In,
  input  logic                         MEMACC_MemReady_In,
  input  logic [DATAWIDTH_DATA-1:0]    MEMACC_MemReadData_InBus,
  output logic                         MEMACC_ACK_Out,
  output logic [DATAWIDTH_DATA-1:0]    MEMACC_ReadData_OutBus,
  output logic                         MEMACC_Busy_Out,
  output logic                         MEMACC_Error_Out,
  output logic                         MEMACC_MemEnable_Out,
  output logic                         MEMACC_MemWrite_Out,
  output logic [DATAWIDTH_ADDRESS-1:0] MEMACC_MemAddress_OutBus,
  output logic [DATAWIDTH_DATA-1:0]    MEMACC_MemWriteData_OutBus
);

  memacc_state_t state;

  logic req_any;
  logic req_ok;
  logic req_bad;
  logic timer_tc;
  logic in_wait;

  assign req_any = MEMACC_RD_In | MEMACC_WRMain_In;
  assign req_ok  = (MEMACC_RD_In ^ MEMACC_WRMain_In)
                 & is_aligned(MEMACC_Address_InBus[1:0]);
  assign req_bad = req_any & ~req_ok;
  assign in_wait = (state == WAIT);

  memacc_timer #(
    .DATAWIDTH_TIMER (DATAWIDTH_TIMER),
    .TERMINAL        (TIMEOUT_CYCLES - 1)
  ) u_timer (
    .clk        (MEMACC_CLOCK_50),
    .rst_n      (MEMACC_ResetInLow_In),
    .clear      (state == DONE || state == FAULT),
    .load       (state == IDLE && req_ok),
    .load_value ('0),
    .enable     (in_wait & ~MEMACC_MemReady_In),
    .terminal   (timer_tc)
  );

  assign MEMACC_Busy_Out = (state != IDLE);

  // Access FSM with registered strobe, ACK, error and data latches.
  always_ff @(posedge MEMACC_CLOCK_50) begin
    if (!MEMACC_ResetInLow_In) begin
      state                      <= IDLE;
      MEMACC_ACK_Out             <= 1'b0;
      MEMACC_ReadData_OutBus     <= '0;
      MEMACC_Error_Out           <= 1'b0;
      MEMACC_MemEnable_Out       <= 1'b0;
      MEMACC_MemWrite_Out        <= 1'b0;
      MEMACC_MemAddress_OutBus   <= '0;
      MEMACC_MemWriteData_OutBus <= '0;
    end else begin
      MEMACC_ACK_Out <= 1'b0;
      // Any fault taken below overrides this clear.
      if (MEMACC_ClearError_In) begin
        MEMACC_Error_Out <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (req_bad) begin
            state                  <= FAULT;
            MEMACC_ACK_Out         <= 1'b1;
            MEMACC_Error_Out       <= 1'b1;
            MEMACC_ReadData_OutBus <= '0;
          end else if (req_ok) begin
            state                      <= WAIT;
            MEMACC_MemEnable_Out       <= 1'b1;
            MEMACC_MemWrite_Out        <= MEMACC_WRMain_In;
            MEMACC_MemAddress_OutBus   <= MEMACC_Address_InBus;
            MEMACC_MemWriteData_OutBus <= MEMACC_WriteData_InBus;
          end
        end
        WAIT: begin
          if (MEMACC_MemReady_In) begin
            state                <= DONE;
            MEMACC_ACK_Out       <= 1'b1;
            MEMACC_MemEnable_Out <= 1'b0;
            if (!MEMACC_MemWrite_Out) begin
              MEMACC_ReadData_OutBus <= MEMACC_MemReadData_InBus;
            end
          end else if (timer_tc) begin
            state                <= FAULT;
            MEMACC_ACK_Out       <= 1'b1;
            MEMACC_MemEnable_Out <= 1'b0;
            MEMACC_Error_Out     <= 1'b1;
            if (!MEMACC_MemWrite_Out) begin
              MEMACC_ReadData_OutBus <= '0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        FAULT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_controller.sv
// Self-checking bench for memory_access_controller.
// Directed plan steps followed by randomized accesses against a model.
module tb_memory_access_controller;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        clr;
  logic        ready;
  logic [31:0] mrdata;
  logic        ack;
  logic [31:0] rdata;
  logic        busy;
  logic        err;
  logic        en;
  logic        mwr;
  logic [31:0] maddr;
  logic [31:0] mwdata;

  int tests = 0;
  int fails = 0;
  int ack_cnt = 0;
  int ack_exp = 0;

  logic [31:0] exp_rdata = '0;
  logic        exp_err = 1'b0;

  memory_access_controller #(
    .DATAWIDTH_ADDRESS (32),
    .DATAWIDTH_DATA    (32),
    .TIMEOUT_CYCLES    (TO),
    .DATAWIDTH_TIMER   (4)
  ) dut (
    .MEMACC_CLOCK_50            (clk),
    .MEMACC_ResetInLow_In       (rst_n),
    .MEMACC_RD_In               (rd),
    .MEMACC_WRMain_In           (wr),
    .MEMACC_Address_InBus       (addr),
    .MEMACC_WriteData_InBus     (wdata),
    .MEMACC_ClearError_In       (clr),
    .MEMACC_MemReady_In         (ready),
    .MEMACC_MemReadData_InBus   (mrdata),
    .MEMACC_ACK_Out             (ack),
    .MEMACC_ReadData_OutBus     (rdata),
    .MEMACC_Busy_Out            (busy),
    .MEMACC_Error_Out           (err),
    .MEMACC_MemEnable_Out       (en),
    .MEMACC_MemWrite_Out        (mwr),
    .MEMACC_MemAddress_OutBus   (maddr),
    .MEMACC_MemWriteData_OutBus (mwdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ack === 1'b1) ack_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access from the request cycle (cycle 0) to its ACK cycle.
  // k = cycle in which memory asserts ready; k > TO means never.
  task automatic access(input logic rq_rd, input logic rq_wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input int k, input logic [31:0] md,
                        input logic clr0, input logic hold);
    logic        legal;
    logic        tmo;
    int          dc;
    logic        err_mid;
    logic        err_end;
    logic [31:0] rd_end;
    logic        en_exp;
    legal = (rq_rd ^ rq_wr) && (a % 4 == 0);
    tmo = legal && (k > TO);
    dc = !legal ? 1 : (tmo ? TO + 1 : k + 1);
    err_mid = clr0 ? 1'b0 : exp_err;
    err_end = (!legal || tmo) ? 1'b1 : err_mid;
    if (!legal) rd_end = '0;
    else if (rq_wr) rd_end = exp_rdata;
    else rd_end = tmo ? 32'h0 : md;
    rd = rq_rd;
    wr = rq_wr;
    addr = a;
    wdata = d;
    clr = clr0;
    ready = 1'($urandom % 2);
    mrdata = $urandom;
    chk("c0_ack", ack, 0);
    chk("c0_busy", busy, 0);
    chk("c0_en", en, 0);
    chk("c0_err", err, exp_err);
    chk("c0_rdata", rdata, exp_rdata);
    for (int c = 1; c <= dc; c++) begin
      tick();
      clr = 1'b0;
      addr = $urandom;
      wdata = $urandom;
      if (c == dc && !hold) begin
        rd = 1'b0;
        wr = 1'b0;
      end
      if (c < dc) ready = (c == k);
      else ready = 1'($urandom % 2);
      mrdata = (c == k) ? md : $urandom;
      en_exp = legal && (c < dc);
      chk("en", en, en_exp);
      chk("ack", ack, c == dc);
      chk("busy", busy, 1);
      chk("err", err, (c == dc) ? err_end : err_mid);
      chk("rdata", rdata, (c == dc) ? rd_end : exp_rdata);
      if (en_exp) begin
        chk("mwr", mwr, rq_wr);
        chk("maddr", maddr, a);
        chk("mwdata", mwdata, d);
      end
    end
    exp_rdata = rd_end;
    exp_err = err_end;
    ack_exp++;
    tick();
  endtask

  task automatic clear_error();
    clr = 1'b1;
    chk("clr_before", err, exp_err);
    tick();
    clr = 1'b0;
    exp_err = 1'b0;
    chk("clr_after", err, 0);
  endtask

  initial begin
    int b2b;
    rst_n = 1'b0;
    rd = 1'b0;
    wr = 1'b0;
    addr = '0;
    wdata = '0;
    clr = 1'b0;
    ready = 1'b0;
    mrdata = '0;
    tick();
    tick();
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en", en, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_maddr", maddr, 0);
    rst_n = 1'b1;
    tick();

    // Read with 3-cycle memory, then immediate-ready write.
    access(1, 0, 32'h100, 32'h0, 3, 32'hDEADBEEF, 0, 0);
    access(0, 1, 32'h204, 32'h12345678, 1, 32'h0, 0, 0);
    // Timeout read; error must hold until cleared.
    access(1, 0, 32'h10C, 32'h0, 99, 32'h0, 0, 0);
    tick();
    tick();
    chk("err_hold", err, 1);
    clear_error();
    // Illegal: both requests, with a coinciding clear.
    access(1, 1, 32'h100, 32'h0, 1, 32'h0, 1, 0);
    clear_error();
    // Illegal: misaligned read.
    access(1, 0, 32'h102, 32'h0, 1, 32'h0, 0, 0);

    // Back-to-back reads with RD held high.
    b2b = ack_cnt;
    access(1, 0, 32'h104, 32'h0, 2, 32'hA5A5_0001, 0, 1);
    access(1, 0, 32'h108, 32'h0, 1, 32'hA5A5_0002, 0, 0);
    tick();
    chk("b2b_acks", ack_cnt - b2b, 2);

    // Reset in the second WAIT cycle of a read.
    rd = 1'b1;
    addr = 32'h300;
    ready = 1'b0;
    tick();
    tick();
    chk("pre_rst_en", en, 1);
    rst_n = 1'b0;
    tick();
    chk("mr_ack", ack, 0);
    chk("mr_busy", busy, 0);
    chk("mr_en", en, 0);
    chk("mr_mwr", mwr, 0);
    chk("mr_maddr", maddr, 0);
    chk("mr_mwdata", mwdata, 0);
    chk("mr_err", err, 0);
    chk("mr_rdata", rdata, 0);
    exp_rdata = '0;
    exp_err = 1'b0;
    rst_n = 1'b1;
    access(1, 0, 32'h300, 32'h0, 2, 32'h0BAD_F00D, 0, 0);

    // Randomized accesses against the model.
    for (int i = 0; i < 40; i++) begin
      logic        r;
      logic        w;
      logic [31:0] a;
      int          k;
      int          sel;
      sel = int'($urandom_range(0, 9));
      r = (sel < 5) || (sel == 9);
      w = (sel >= 5);
      a = {$urandom_range(0, 1023), 2'b00};
      if (sel == 8) a[1:0] = 2'($urandom_range(1, 3));
      k = ($urandom_range(0, 7) == 0) ? TO + 1
        : int'($urandom_range(1, TO));
      access(r, w, a, $urandom, k, $urandom,
             1'($urandom % 4 == 0), 0);
      if ($urandom % 5 == 0) clear_error();
    end

    tick();
    chk("ack_total", ack_cnt, ack_exp);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memory_access_controller.md
Name: memory_access_controller

Overview:
- Sequences every main-memory read and write requested by the microcoded control unit, and returns the ACK that releases the control-store address incrementer.
- Sits between the control unit's RD/WR microword fields and the external memory port.
- Latches address and data, waits a variable number of cycles for memory, enforces a timeout and alignment check, and returns read data to the datapath.

Parameters:
- DATAWIDTH_ADDRESS, 32, byte-address width.
- DATAWIDTH_DATA, 32, data word width.
- TIMEOUT_CYCLES, 15, WAIT cycles without ready before an access is aborted; must be ≥1.
- DATAWIDTH_TIMER, 4, width of the wait counter; must hold TIMEOUT_CYCLES.

Ports:
- MEMACC_CLOCK_50  in  1  system clock, all logic on rising edge.
- MEMACC_ResetInLow_In  in  1  reset; synchronous, active-low.
- MEMACC_RD_In  in  1  read request from microword, level, held until ACK.
- MEMACC_WRMain_In  in  1  write request from microword, level, held until ACK.
- MEMACC_Address_InBus  in  DATAWIDTH_ADDRESS  byte address from datapath.
- MEMACC_WriteData_InBus  in  DATAWIDTH_DATA  store data from datapath.
- MEMACC_ClearError_In  in  1  clears sticky error flag.
- MEMACC_MemReady_In  in  1  memory has completed the current access.
- MEMACC_MemReadData_InBus  in  DATAWIDTH_DATA  memory read data, valid with ready.
- MEMACC_ACK_Out  out  1  one-cycle completion pulse to the control unit.
- MEMACC_ReadData_OutBus  out  DATAWIDTH_DATA  latched read result.
- MEMACC_Busy_Out  out  1  high in any state except IDLE.
- MEMACC_Error_Out  out  1  sticky fault flag.
- MEMACC_MemEnable_Out  out  1  memory strobe.
- MEMACC_MemWrite_Out  out  1  1 = write, 0 = read; valid with enable.
- MEMACC_MemAddress_OutBus  out  DATAWIDTH_ADDRESS  latched address.
- MEMACC_MemWriteData_OutBus  out  DATAWIDTH_DATA  latched store data.

Behaviour:
- Reset (ResetInLow=0 at a clock edge):
  - state IDLE, timer 0.
  - All outputs 0, including ReadData and Error.
  - Reset wins over every other event, including an access in WAIT; the memory strobe drops on the next edge.
- States and transitions:
  - IDLE → WAIT: RD xor WRMain high and Address[1:0]==0. Latch address, write data and direction. Timer=0.
  - IDLE → FAULT: RD and WRMain both high, or Address[1:0]!=0 with a request. No memory strobe is ever issued.
  - WAIT:
    - MemEnable=1, MemWrite=latched direction, address and data outputs stable.
    - MemReady=1 → DONE; on a read, ReadData <= MemReadData in the same edge.
    - Otherwise timer+1. If timer==TIMEOUT_CYCLES-1 and ready is low → FAULT.
  - DONE: ACK=1 for exactly this cycle, MemEnable=0 → IDLE.
  - FAULT:
    - ACK=1 for one cycle. Error set, stays set.
    - ReadData <= 0 on a read or illegal request; unchanged on a write.
    - → IDLE.
- Latency:
  - Request seen in cycle 0; MemEnable from cycle 1.
  - Ready sampled in cycle k (k≥1) gives ACK in cycle k+1. Minimum request-to-ACK is 2 cycles.
- Back-to-back: in the IDLE cycle after ACK a still-high RD/WR is a new request. Microcode advances on ACK, so this is the next microinstruction's access and gives no duplicate.
- Inputs are ignored outside IDLE; address and data changes mid-access have no effect.
- Error:
  - Cleared only by ClearError in a cycle where no FAULT transition occurs.
  - If ClearError and a new fault coincide, Error stays 1.
- Ready in IDLE or DONE is ignored.
- A timeout with a late ready on the same edge counts as a completion, because ready has priority.

Decomposition:
- Shared package memacc_pkg holds:
  - state encoding constants: IDLE=2'd0, WAIT=2'd1, DONE=2'd2, FAULT=2'd3.
  - the alignment-mask constant.
- Optional sub-module memacc_timer: a loadable, clearable up-counter with a terminal-count output, parameterized by DATAWIDTH_TIMER.
- The FSM and datapath latches stay in the top module.

Test Plan:
- Read, 3-cycle memory: RD=1, Address=0x100; ready in cycle 3 with data 0xDEADBEEF.
  - Expect MemEnable cycles 1-3, MemWrite=0, ACK only in cycle 4.
  - ReadData=0xDEADBEEF, Error=0.
- Write, immediate ready: WRMain=1, Address=0x204, WriteData=0x12345678; ready in cycle 1.
  - Expect MemWrite=1, MemAddress=0x204, MemWriteData=0x12345678.
  - ACK in cycle 2; ReadData unchanged.
- Timeout: RD=1, ready never asserted.
  - Expect exactly 15 MemEnable cycles, then ACK plus Error=1.
  - ReadData=0; Error holds until ClearError pulse.
- Illegal requests, each with no MemEnable, ACK in cycle 1, Error=1:
  - RD=WRMain=1 at 0x100.
  - RD=1 at 0x102.
- Reset mid-access: RD=1, ResetInLow=0 in cycle 2 of WAIT.
  - Expect all outputs 0 next edge, state IDLE, no ACK.
  - After release with RD still high, a fresh access starts.
- Back-to-back: read completes, RD stays high with new Address 0x108.
  - Second access begins in the cycle after ACK; a separate ACK follows.
  - Exactly two ACK pulses total.
